// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality check for the batching FIFO family.
// Latency: none (package, elaboration-time only).
// Backpressure: not applicable.
package fifo_pkg;

    // Pointer width for a DEPTH-entry ring; DEPTH is a power of two >= 2.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width, able to hold 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit params_ok(input int depth, input int batch, input int frame,
                                     input int afull, input int chans, input int dw);
        bit pow2;
        pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
        return pow2 && (batch >= 1) && (batch <= depth) && (frame >= 1) &&
               (afull >= 1) && (afull <= depth) && (chans >= 1) && (dw >= 1);
    endfunction

endpackage

// File: rtl/fifo_mc_ram.sv
// Simple dual-port entry store: one write port, one registered read port with enable.
// Latency: 1 cycle from re to rdata; rdata holds while re is low.
// Backpressure: none; the caller guarantees legal addresses.
module fifo_mc_ram #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array: no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register: cleared on reset, updated only on an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_batch_mc.sv
// Multi-channel batching FIFO with end-of-frame tags, flush and almost-full; FIFO_ERR_FLAGS_EN adds sticky ovf/udf flags.
// Latency: write visible (empty=0) next cycle; read data one cycle after an accepted read.
// Backpressure: writes dropped while full, reads ignored while empty; rd_valid is a one-cycle pulse.
module fifo_batch_mc
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CHANNELS     = 16,
    parameter int DEPTH        = 256,
    parameter int BATCH_SIZE   = 28,
    parameter int FRAME_PIXELS = 196,
    parameter int AFULL_THRESH = 240
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             wr_en,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   wr_data,
    input  logic                             rd_en,
    output logic [CHANNELS*DATA_WIDTH-1:0]   rd_data,
    output logic                             rd_valid,
    output logic                             rd_last,
    output logic                             empty,
    output logic                             full,
    output logic                             almost_full,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             batch_ready,
    output logic                             last_batch,
    output logic                             ovf_err,
    output logic                             udf_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int WW = CHANNELS * DATA_WIDTH;
    localparam int FW = $clog2(FRAME_PIXELS + 1);

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] BATCH_C    = CW'(BATCH_SIZE);
    localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_THRESH);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_PIXELS - 1);

    if (!params_ok(DEPTH, BATCH_SIZE, FRAME_PIXELS, AFULL_THRESH, CHANNELS, DATA_WIDTH)) begin : g_param_check
        $error("fifo_batch_mc: illegal parameter combination");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [FW-1:0]    wr_pix;
    logic [CW-1:0]    tail_cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    tail_nxt;
    logic [DEPTH-1:0] tag_vec;
    logic             wr_acc;
    logic             rd_acc;
    logic             wr_tag;
    logic             rd_tag;
    logic [WW:0]      ram_q;

    // Acceptance uses registered flags only; flush suppresses both sides.
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;
    assign wr_tag = (wr_pix == FRAME_LAST);
    // The RAM read is registered, so a flop copy of each tag lets tail_cnt drop in the same cycle as the read.
    assign rd_tag = tag_vec[rd_ptr];

    // Next-state occupancy and stored end-of-frame count.
    always_comb begin
        cnt_nxt  = count;
        tail_nxt = tail_cnt;
        if (flush) begin
            cnt_nxt  = '0;
            tail_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   cnt_nxt = count + CW'(1);
                2'b01:   cnt_nxt = count - CW'(1);
                default: cnt_nxt = count;
            endcase
            if ((wr_acc & wr_tag) && !(rd_acc & rd_tag)) begin
                tail_nxt = tail_cnt + CW'(1);
            end else if ((rd_acc & rd_tag) && !(wr_acc & wr_tag)) begin
                tail_nxt = tail_cnt - CW'(1);
            end
        end
    end

    // Pointers and frame pixel position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_pix <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_pix <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
                wr_pix <= wr_tag ? '0 : wr_pix + FW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Counters and status flags, all registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            tail_cnt    <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            batch_ready <= 1'b0;
            last_batch  <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            count       <= cnt_nxt;
            tail_cnt    <= tail_nxt;
            empty       <= (cnt_nxt == '0);
            full        <= (cnt_nxt == DEPTH_C);
            almost_full <= (cnt_nxt >= AFULL_C);
            batch_ready <= (cnt_nxt >= BATCH_C) || (tail_nxt != '0);
            last_batch  <= (tail_nxt != '0);
            rd_valid    <= rd_acc;
        end
    end

    // Tag shadow, written alongside the RAM entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vec <= '0;
        end else if (wr_acc) begin
            tag_vec[wr_ptr] <= wr_tag;
        end
    end

    fifo_mc_ram #(
        .WIDTH (WW + 1),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata ({wr_tag, wr_data}),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    assign rd_data = ram_q[WW-1:0];
    assign rd_last = ram_q[WW];

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky misuse flags; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_en & full) begin
                ovf_err <= 1'b1;
            end
            if (rd_en & empty) begin
                udf_err <= 1'b1;
            end
        end
    end
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_batch_mc.sv
// Directed bench for fifo_batch_mc at default parameters; honours FIFO_ERR_FLAGS_EN.
// Latency: inputs change 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: exercised via full/empty boundary scenarios.
module tb_fifo_batch_mc;

    localparam int DW    = 8;
    localparam int CH    = 16;
    localparam int DEPTH = 256;
    localparam int FRAME = 196;
    localparam int WW    = DW * CH;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [WW-1:0] wr_data = '0;
    logic [WW-1:0] rd_data;
    logic          rd_valid, rd_last, empty, full, almost_full;
    logic          batch_ready, last_batch, ovf_err, udf_err;
    logic [8:0]    count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_batch_mc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_last     (rd_last),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .batch_ready (batch_ready),
        .last_batch  (last_batch),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    function automatic logic [WW-1:0] mk_word(input int idx);
        logic [WW-1:0] w;
        for (int c = 0; c < CH; c++) w[c*DW +: DW] = 8'((idx + c) % 256);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_n(input int base, input int n);
        wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = mk_word(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rd_valid, rd_last, empty, full, almost_full, batch_ready, last_batch, ovf_err, udf_err} !== 9'b001000000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b",
                {rd_valid, rd_last, empty, full, almost_full, batch_ready, last_batch, ovf_err, udf_err}, 9'b001000000);
        end
        checks++;
        if (count !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    endtask

    task automatic test_batch();
        do_reset();
        write_n(0, 27);
        checks++;
        if (count !== 9'd27) begin errors++; $display("FAIL batch_count27: got %0d expected 27", count); end
        checks++;
        if (batch_ready !== 1'b0) begin errors++; $display("FAIL batch_ready27: got %b expected 0", batch_ready); end
        write_n(27, 1);
        checks++;
        if (batch_ready !== 1'b1) begin errors++; $display("FAIL batch_ready28: got %b expected 1", batch_ready); end
        checks++;
        if (last_batch !== 1'b0) begin errors++; $display("FAIL batch_last28: got %b expected 0", last_batch); end
    endtask

    task automatic test_frame();
        do_reset();
        write_n(0, FRAME - 1);
        checks++;
        if (last_batch !== 1'b0) begin errors++; $display("FAIL frame_last195: got %b expected 0", last_batch); end
        write_n(FRAME - 1, 1);
        checks++;
        if (last_batch !== 1'b1) begin errors++; $display("FAIL frame_last196: got %b expected 1", last_batch); end
        rd_en = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1) begin errors++; $display("FAIL frame_rd_valid[%0d]: got %b expected 1", i, rd_valid); end
            checks++;
            if (rd_data !== mk_word(i)) begin errors++; $display("FAIL frame_rd_data[%0d]: got %h expected %h", i, rd_data, mk_word(i)); end
            checks++;
            if (rd_last !== (i == FRAME - 1)) begin errors++; $display("FAIL frame_rd_last[%0d]: got %b expected %b", i, rd_last, (i == FRAME - 1)); end
            if (i == FRAME - 2) begin
                checks++;
                if (last_batch !== 1'b1) begin errors++; $display("FAIL frame_last_hold: got %b expected 1", last_batch); end
            end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL frame_empty_after: got %b expected 1", empty); end
        checks++;
        if (last_batch !== 1'b0) begin errors++; $display("FAIL frame_last_after: got %b expected 0", last_batch); end
    endtask

    task automatic test_full();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = mk_word(i);
            tick();
            checks++;
            if (count !== 9'(i + 1)) begin errors++; $display("FAIL full_count[%0d]: got %0d expected %0d", i, count, i + 1); end
            checks++;
            if (almost_full !== ((i + 1) >= 240)) begin errors++; $display("FAIL full_afull[%0d]: got %b expected %b", i, almost_full, ((i + 1) >= 240)); end
            checks++;
            if (full !== ((i + 1) == DEPTH)) begin errors++; $display("FAIL full_flag[%0d]: got %b expected %b", i, full, ((i + 1) == DEPTH)); end
        end
        wr_data = mk_word(500);
        tick();
        wr_en = 1'b0;
        checks++;
        if (count !== 9'd256) begin errors++; $display("FAIL full_drop_count: got %0d expected 256", count); end
        checks++;
        if (ovf_err !== ERR_EN) begin errors++; $display("FAIL full_ovf_err: got %b expected %b", ovf_err, ERR_EN); end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = mk_word(501);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 9'd255) begin errors++; $display("FAIL full_wrrd_count: got %0d expected 255", count); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL full_wrrd_full: got %b expected 0", full); end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== mk_word(0)) begin
            errors++; $display("FAIL full_wrrd_read: got valid=%b data=%h expected valid=1 data=%h", rd_valid, rd_data, mk_word(0));
        end
    endtask

    task automatic test_simul();
        do_reset();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = mk_word(77);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 9'd1) begin errors++; $display("FAIL simul_count: got %0d expected 1", count); end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL simul_rd_valid: got %b expected 0", rd_valid); end
        checks++;
        if (udf_err !== ERR_EN) begin errors++; $display("FAIL simul_udf_err: got %b expected %b", udf_err, ERR_EN); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== mk_word(77)) begin
            errors++; $display("FAIL simul_read: got valid=%b data=%h expected valid=1 data=%h", rd_valid, rd_data, mk_word(77));
        end
        checks++;
        if (empty !== 1'b1 || count !== 9'd0) begin errors++; $display("FAIL simul_empty: got empty=%b count=%0d expected 1/0", empty, count); end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== mk_word(77)) begin
            errors++; $display("FAIL simul_hold: got valid=%b data=%h expected valid=0 data=%h", rd_valid, rd_data, mk_word(77));
        end
    endtask

    task automatic test_stream();
        int ri;
        int lasts;
        ri = 0;
        lasts = 0;
        do_reset();
        write_n(0, 200);
        for (int i = 0; i < 600; i++) begin
            wr_en = (i < 400);
            rd_en = 1'b1;
            wr_data = mk_word(200 + i);
            tick();
            checks++;
            if (rd_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", ri, rd_valid); end
            checks++;
            if (rd_data !== mk_word(ri)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", ri, rd_data, mk_word(ri)); end
            checks++;
            if (rd_last !== (((ri + 1) % FRAME) == 0)) begin errors++; $display("FAIL stream_last[%0d]: got %b expected %b", ri, rd_last, (((ri + 1) % FRAME) == 0)); end
            if (rd_last === 1'b1) lasts++;
            ri++;
            if (i == 399) begin
                checks++;
                if (count !== 9'd200) begin errors++; $display("FAIL stream_occupancy: got %0d expected 200", count); end
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (lasts != 3) begin errors++; $display("FAIL stream_last_pulses: got %0d expected 3", lasts); end
        checks++;
        if (empty !== 1'b1 || count !== 9'd0 || last_batch !== 1'b0) begin
            errors++; $display("FAIL stream_drained: got empty=%b count=%0d last_batch=%b expected 1/0/0", empty, count, last_batch);
        end
    endtask

    task automatic test_flush();
        do_reset();
        write_n(0, 50);
        checks++;
        if (count !== 9'd50) begin errors++; $display("FAIL flush_pre_count: got %0d expected 50", count); end
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = mk_word(999);
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if ({empty, full, almost_full, batch_ready, last_batch, rd_valid} !== 6'b100000) begin
            errors++; $display("FAIL flush_flags: got %b expected %b", {empty, full, almost_full, batch_ready, last_batch, rd_valid}, 6'b100000);
        end
        checks++;
        if (count !== 9'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        write_n(1000, FRAME - 1);
        checks++;
        if (last_batch !== 1'b0) begin errors++; $display("FAIL flush_last195: got %b expected 0", last_batch); end
        write_n(1000 + FRAME - 1, 1);
        checks++;
        if (last_batch !== 1'b1) begin errors++; $display("FAIL flush_last196: got %b expected 1", last_batch); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== mk_word(1000)) begin errors++; $display("FAIL flush_first_word: got %h expected %h", rd_data, mk_word(1000)); end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_n(0, 30);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || batch_ready !== 1'b1) begin
            errors++; $display("FAIL arst_pre: got valid=%b batch_ready=%b expected 1/1", rd_valid, batch_ready);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_valid, rd_last, empty, full, almost_full, batch_ready, last_batch, ovf_err, udf_err} !== 9'b001000000) begin
            errors++; $display("FAIL arst_flags: got %b expected %b",
                {rd_valid, rd_last, empty, full, almost_full, batch_ready, last_batch, ovf_err, udf_err}, 9'b001000000);
        end
        checks++;
        if (count !== 9'd0 || rd_data !== '0) begin errors++; $display("FAIL arst_count_data: got count=%0d data=%h expected 0/0", count, rd_data); end
        #2;
        rst_n = 1'b1;
        tick();
        write_n(7, 1);
        checks++;
        if (count !== 9'd1 || empty !== 1'b0) begin errors++; $display("FAIL arst_resume: got count=%0d empty=%b expected 1/0", count, empty); end
    endtask

    initial begin
        test_reset();
        test_batch();
        test_frame();
        test_full();
        test_simul();
        test_stream();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
